// File: rtl/combo_pkg.sv
// combo_pkg: shared types and constants for the combo_lut block.
//   state_e    - sweep controller states
//   TtDefault  - reset truth table, z = (a&b) | ((c^d)&~e) with a as vector MSB
//   tt_width() - truth-table width (2^n_in) for an n_in-input function
package combo_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSweep,
    StDone
  } state_e;

  localparam logic [31:0] TtDefault = 32'hFF14_1414;

  function automatic int unsigned tt_width(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

endpackage

// File: rtl/combo_lut_if.sv
// combo_lut_if: request/response bundle of the combo_lut block.
//   in_valid/in_vec     - evaluate request
//   tt_we/tt_wdata      - truth-table load
//   start               - sweep request pulse
//   out_valid/z/out_vec - registered lookup result and the vector that produced it
//   busy/done/ones_cnt  - sweep status and ones-count signature
// The master modport drives requests; the slave modport is the block side.
interface combo_lut_if
  import combo_pkg::*;
#(
  parameter int unsigned N_IN = 5
);
  localparam int unsigned TtW = tt_width(N_IN);

  logic            in_valid;
  logic [N_IN-1:0] in_vec;
  logic            tt_we;
  logic [TtW-1:0]  tt_wdata;
  logic            start;
  logic            out_valid;
  logic            z;
  logic [N_IN-1:0] out_vec;
  logic            busy;
  logic            done;
  logic [N_IN:0]   ones_cnt;

  modport master (
    output in_valid, in_vec, tt_we, tt_wdata, start,
    input  out_valid, z, out_vec, busy, done, ones_cnt
  );

  modport slave (
    input  in_valid, in_vec, tt_we, tt_wdata, start,
    output out_valid, z, out_vec, busy, done, ones_cnt
  );

endinterface

// File: rtl/combo_lut_core.sv
// combo_lut_core: truth-table register with one write port and one registered read port.
//   clk, rst      - clock, synchronous active-high reset (table reloads TT_INIT)
//   we_i, wdata_i - table load
//   rd_en_i       - perform a lookup at rd_addr_i this cycle
//   rd_addr_i     - table index
//   rd_bit_o      - combinational table[rd_addr_i] (current table contents)
//   out_valid_o   - lookup result valid (one cycle after rd_en_i)
//   z_o           - registered lookup result
//   out_vec_o     - index that produced z_o
module combo_lut_core
  import combo_pkg::*;
#(
  parameter int unsigned                N_IN    = 5,
  parameter logic [tt_width(N_IN)-1:0]  TT_INIT = TtDefault
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we_i,
  input  logic [tt_width(N_IN)-1:0] wdata_i,
  input  logic                      rd_en_i,
  input  logic [N_IN-1:0]           rd_addr_i,
  output logic                      rd_bit_o,
  output logic                      out_valid_o,
  output logic                      z_o,
  output logic [N_IN-1:0]           out_vec_o
);
  localparam int unsigned TtW = tt_width(N_IN);

  logic [TtW-1:0]  tt_q;
  logic            out_valid_q;
  logic            z_q;
  logic [N_IN-1:0] out_vec_q;

  // Reads see the table before any same-cycle write lands.
  assign rd_bit_o = tt_q[rd_addr_i];

  always_ff @(posedge clk) begin
    if (rst) begin
      tt_q        <= TT_INIT;
      out_valid_q <= 1'b0;
      z_q         <= 1'b0;
      out_vec_q   <= '0;
    end else begin
      if (we_i) begin
        tt_q <= wdata_i;
      end
      out_valid_q <= rd_en_i;
      if (rd_en_i) begin
        z_q       <= rd_bit_o;
        out_vec_q <= rd_addr_i;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign z_o         = z_q;
  assign out_vec_o   = out_vec_q;

endmodule

// File: rtl/combo_lut.sv
// combo_lut: programmable N_IN-input logic function with a registered one-bit result
// and a self-check sweep that walks every input vector and counts the ones.
//   clk, rst - clock, synchronous active-high reset
//   bus      - combo_lut_if slave: evaluate, table load, sweep start, results, status
// Evaluate and sweep share the core's single read port; the FSM steers it.
module combo_lut
  import combo_pkg::*;
#(
  parameter int unsigned               N_IN    = 5,
  parameter logic [tt_width(N_IN)-1:0] TT_INIT = TtDefault
) (
  input  logic        clk,
  input  logic        rst,
  combo_lut_if.slave  bus
);
  localparam logic [N_IN-1:0] IdxMax = '1;

  state_e          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [N_IN:0]   cnt_q, cnt_d;
  logic            rd_en;
  logic [N_IN-1:0] rd_addr;
  logic            rd_bit;
  logic            tt_we_gated;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    rd_en       = 1'b0;
    rd_addr     = bus.in_vec;
    tt_we_gated = 1'b0;
    unique case (state_q)
      StIdle: begin
        rd_en       = bus.in_valid;
        tt_we_gated = bus.tt_we;
        if (bus.start) begin
          state_d = StSweep;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      StSweep: begin
        rd_en   = 1'b1;
        rd_addr = idx_q;
        // Count from the table directly so the total is final alongside the last result.
        cnt_d   = cnt_q + (N_IN + 1)'(rd_bit);
        if (idx_q == IdxMax) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  combo_lut_core #(
    .N_IN    (N_IN),
    .TT_INIT (TT_INIT)
  ) u_core (
    .clk         (clk),
    .rst         (rst),
    .we_i        (tt_we_gated),
    .wdata_i     (bus.tt_wdata),
    .rd_en_i     (rd_en),
    .rd_addr_i   (rd_addr),
    .rd_bit_o    (rd_bit),
    .out_valid_o (bus.out_valid),
    .z_o         (bus.z),
    .out_vec_o   (bus.out_vec)
  );

  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = (state_q == StDone);
  assign bus.ones_cnt = cnt_q;

endmodule

// File: tb/tb_combo_lut.sv
module tb_combo_lut;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  combo_lut_if #(.N_IN(5)) bus ();

  combo_lut #(.N_IN(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference function: a is vector bit 4, e is bit 0.
  function automatic logic model_z(input int k);
    logic a, b, c, d, e;
    a = k[4]; b = k[3]; c = k[2]; d = k[1]; e = k[0];
    return (a & b) | ((c ^ d) & ~e);
  endfunction

  function automatic logic [31:0] model_tt();
    logic [31:0] t;
    for (int k = 0; k < 32; k++) t[k] = model_z(k);
    return t;
  endfunction

  // {out_valid, z, out_vec, busy, done}
  function automatic logic [8:0] obs();
    return {bus.out_valid, bus.z, bus.out_vec, bus.busy, bus.done};
  endfunction

  function automatic logic [2:0] ctl();
    return {bus.out_valid, bus.busy, bus.done};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (obs() !== 9'h000) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want %b", obs(), 9'h000);
    end
    n_cmp++;
    if (bus.ones_cnt !== 6'd0) begin
      n_err++;
      $display("FAIL reset_ones_cnt: got %0d want 0", bus.ones_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_evaluate();
    bus.in_valid = 1'b1;
    bus.in_vec   = 5'b11000;
    tick();
    n_cmp++;
    if (obs() !== {1'b1, 1'b1, 5'b11000, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL eval_11000: got %b want %b", obs(), {1'b1, 1'b1, 5'b11000, 2'b00});
    end
    bus.in_vec = 5'b01001;
    tick();
    n_cmp++;
    if (obs() !== {1'b1, 1'b0, 5'b01001, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL eval_01001: got %b want %b", obs(), {1'b1, 1'b0, 5'b01001, 2'b00});
    end
    bus.in_valid = 1'b0;
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL eval_idle_valid: got %b want 0", bus.out_valid);
    end
  endtask

  // Sweep from IDLE; optionally disturb the inputs mid-sweep (all must be ignored).
  task automatic test_sweep(input string name, input logic [31:0] exp_tt,
                            input logic [5:0] exp_cnt, input bit disturb);
    logic [8:0] want;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_cmp++;
    if (ctl() !== 3'b010) begin
      n_err++;
      $display("FAIL %s_first_busy: got %b want 010", name, ctl());
    end
    for (int k = 0; k < 32; k++) begin
      if (disturb && k == 5) begin
        bus.tt_we    = 1'b1;
        bus.tt_wdata = 32'h0;
        bus.in_valid = 1'b1;
        bus.in_vec   = 5'b11000;
        bus.start    = 1'b1;
      end
      tick();
      bus.tt_we    = 1'b0;
      bus.in_valid = 1'b0;
      bus.start    = 1'b0;
      want = {1'b1, exp_tt[k], 5'(k), 1'b1, (k == 31)};
      n_cmp++;
      if (obs() !== want) begin
        n_err++;
        $display("FAIL %s_vec%0d: got %b want %b", name, k, obs(), want);
      end
      if (k == 31) begin
        n_cmp++;
        if (bus.ones_cnt !== exp_cnt) begin
          n_err++;
          $display("FAIL %s_ones_cnt: got %0d want %0d", name, bus.ones_cnt, exp_cnt);
        end
      end
    end
    tick();
    n_cmp++;
    if (ctl() !== 3'b000 || bus.ones_cnt !== exp_cnt) begin
      n_err++;
      $display("FAIL %s_after_done: got ctl %b cnt %0d want ctl 000 cnt %0d",
               name, ctl(), bus.ones_cnt, exp_cnt);
    end
  endtask

  task automatic load_table(input logic [31:0] t);
    bus.tt_we    = 1'b1;
    bus.tt_wdata = t;
    tick();
    bus.tt_we    = 1'b0;
  endtask

  task automatic test_table_write();
    load_table(32'h0);
    test_sweep("zero_tt", 32'h0, 6'd0, 1'b0);
    load_table(32'hFFFF_FFFF);
    test_sweep("ones_tt", 32'hFFFF_FFFF, 6'd32, 1'b0);
    load_table(model_tt());
  endtask

  task automatic test_busy_ignore();
    test_sweep("disturbed", model_tt(), 6'd14, 1'b1);
    test_sweep("after_disturb", model_tt(), 6'd14, 1'b0);
  endtask

  task automatic test_we_with_eval();
    bus.tt_we    = 1'b1;
    bus.tt_wdata = 32'h1;
    bus.in_valid = 1'b1;
    bus.in_vec   = 5'd0;
    tick();
    bus.tt_we = 1'b0;
    n_cmp++;
    if (obs() !== {1'b1, 1'b0, 5'd0, 2'b00}) begin
      n_err++;
      $display("FAIL we_eval_old: got %b want %b", obs(), {1'b1, 1'b0, 5'd0, 2'b00});
    end
    tick();
    bus.in_valid = 1'b0;
    n_cmp++;
    if (obs() !== {1'b1, 1'b1, 5'd0, 2'b00}) begin
      n_err++;
      $display("FAIL we_eval_new: got %b want %b", obs(), {1'b1, 1'b1, 5'd0, 2'b00});
    end
    tick();
  endtask

  // Table holds 32'h1 here: the same-cycle lookup of 24 must see bit 24 = 0,
  // while the sweep runs on the newly written default table.
  task automatic test_simultaneous();
    bit seen;
    bus.tt_we    = 1'b1;
    bus.tt_wdata = model_tt();
    bus.in_valid = 1'b1;
    bus.in_vec   = 5'd24;
    bus.start    = 1'b1;
    tick();
    bus.tt_we    = 1'b0;
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    n_cmp++;
    if (obs() !== {1'b1, 1'b0, 5'd24, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL simul_eval: got %b want %b", obs(), {1'b1, 1'b0, 5'd24, 2'b10});
    end
    tick();
    n_cmp++;
    if (obs() !== {1'b1, model_z(0), 5'd0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL simul_vec0: got %b want %b", obs(), {1'b1, model_z(0), 5'd0, 2'b10});
    end
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (bus.done) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b1 || bus.ones_cnt !== 6'd14) begin
      n_err++;
      $display("FAIL simul_done: got done_seen %b cnt %0d want 1 14", seen, bus.ones_cnt);
    end
    tick();
  endtask

  task automatic test_reset_mid_sweep();
    int n_done;
    load_table(32'h0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (obs() !== 9'h000 || bus.ones_cnt !== 6'd0) begin
      n_err++;
      $display("FAIL rst_mid: got %b cnt %0d want 000000000 cnt 0", obs(), bus.ones_cnt);
    end
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done || bus.busy) n_done++;
    end
    n_cmp++;
    if (n_done !== 0) begin
      n_err++;
      $display("FAIL rst_no_done: got %0d busy/done cycles want 0", n_done);
    end
    test_sweep("post_rst", model_tt(), 6'd14, 1'b0);
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_vec   = '0;
    bus.tt_we    = 1'b0;
    bus.tt_wdata = '0;
    bus.start    = 1'b0;
    test_reset();
    test_evaluate();
    test_sweep("default", model_tt(), 6'd14, 1'b0);
    test_table_write();
    test_busy_ignore();
    test_we_with_eval();
    test_simultaneous();
    test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
